// File: rtl/median3_stream_filter.sv
// rtl/median3_stream_filter.sv - streaming 3-tap sliding-window median filter
//
// Impulse-noise rejector between a sample source and downstream processing.
// Each accepted input sample shifts into a 3-deep window. Once the window is
// full, the median of the window is registered onto the output stream.
//
// Optional feature macro: MEDIAN_EDGE_REPLICATE_EN
//   defined     : the first sample after reset/flush fills all three taps, so
//                 every accepted sample produces one output.
//   not defined : outputs start at the third accepted sample.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    input sample valid
//   in_ready    filter can accept a sample this cycle
//   in_data     unsigned input sample, DATA_W bits
//   flush       drop the partial window and restart fill (pulse or level)
//   out_valid   out_data holds a median
//   out_ready   downstream accepts out_data
//   out_data    registered window median, DATA_W bits
//   fill_level  samples held in the window, 0..3

module median3_stream_filter #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        fill_level
);

   typedef enum logic [1:0] {
      FILL0 = 2'd0,
      FILL1 = 2'd1,
      FILL2 = 2'd2,
      RUN   = 2'd3
   } fill_t;

   fill_t             fill;
   // w0 is the newest held sample, w1 the one before. At the moment a median
   // is formed the window is {in_data, w0, w1}, so the oldest tap never needs
   // its own register.
   logic [DATA_W-1:0] w0;
   logic [DATA_W-1:0] w1;
   logic              accept;

   // Unsigned median: clamp c into the [min(a,b), max(a,b)] interval.
   // Ties fall out naturally (median(4,4,2) = 4).
   function automatic logic [DATA_W-1:0] median3(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] c
   );
      logic [DATA_W-1:0] lo;
      logic [DATA_W-1:0] hi;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      if (c < lo)
         return lo;
      else if (c > hi)
         return hi;
      else
         return c;
   endfunction

   // A held output blocks new input unless it is being taken this cycle;
   // this keeps out_data stable and the window frozen under backpressure.
   assign in_ready   = !flush && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign fill_level = fill;

   always_ff @(posedge clk) begin
      if (rst) begin
         fill      <= FILL0;
         w0        <= '0;
         w1        <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         // Handshake clears the output; a median loaded below overrides it.
         if (out_valid && out_ready)
            out_valid <= 1'b0;

         if (flush) begin
            // Window contents become don't-care; a pending output survives.
            fill <= FILL0;
         end else if (accept) begin
            w1 <= w0;
            w0 <= in_data;
`ifdef MEDIAN_EDGE_REPLICATE_EN
            if (fill == FILL0) begin
               // Replicate the first sample into every tap so it is its own median.
               w1        <= in_data;
               fill      <= RUN;
               out_data  <= in_data;
               out_valid <= 1'b1;
            end else
`endif
            begin
               case (fill)
                  FILL0:   fill <= FILL1;
                  FILL1:   fill <= FILL2;
                  default: begin
                     fill      <= RUN;
                     out_data  <= median3(in_data, w0, w1);
                     out_valid <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_median3_stream_filter.sv
// tb/tb_median3_stream_filter.sv - self-checking bench for median3_stream_filter

module tb_median3_stream_filter;

   localparam int DATA_W = 8;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        fill_level;

   int n_vec = 0;
   int n_err = 0;

   int hist[$];    // samples in the current window, oldest first
   int exp_q[$];   // medians owed to the output stream
   int got[$];     // values observed crossing the output handshake
   int want[$];    // hand-computed literal expectations

   median3_stream_filter #(.DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .fill_level (fill_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int med3(input int a, input int b, input int c);
      int t;
      if (a > b) begin t = a; a = b; b = t; end
      if (b > c) begin t = b; b = c; c = t; end
      if (a > b) begin t = a; a = b; b = t; end
      return b;
   endfunction

   // Model and compare: checks outputs, then advances the model for the next edge.
   always @(negedge clk) begin
      int  lvl;
      bit  exp_ready;
      if (rst) begin
         hist.delete();
         exp_q.delete();
      end else begin
         lvl = (hist.size() > 3) ? 3 : hist.size();
         chk("fill_level", int'(fill_level), lvl);
         chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
         if (exp_q.size() != 0)
            chk("out_data", int'(out_data), exp_q[0]);
         exp_ready = !flush && (exp_q.size() == 0 || out_ready);
         chk("in_ready", int'(in_ready), int'(exp_ready));
         if (out_valid && out_ready)
            got.push_back(int'(out_data));
         if (exp_q.size() != 0 && out_ready)
            void'(exp_q.pop_front());
         if (flush) begin
            hist.delete();
         end else if (in_valid && exp_ready) begin
`ifdef MEDIAN_EDGE_REPLICATE_EN
            if (hist.size() == 0) begin
               hist.push_back(int'(in_data));
               hist.push_back(int'(in_data));
            end
`endif
            hist.push_back(int'(in_data));
            if (hist.size() > 3)
               void'(hist.pop_front());
            if (hist.size() == 3)
               exp_q.push_back(med3(hist[0], hist[1], hist[2]));
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_fill_level", int'(fill_level), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      got.delete();
   endtask

   task automatic send(input int v);
      bit acc;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data = v[DATA_W-1:0];
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         if (in_ready) acc = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_got(input string name);
      chk({name, "_count"}, got.size(), want.size());
      for (int i = 0; i < want.size() && i < got.size(); i++)
         chk({name, "_value"}, got[i], want[i]);
      got.delete();
   endtask

   initial begin
      int s1[5];
      int lv[5];
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      flush = 1'b0;
      out_ready = 1'b1;

      // Basic stream with per-accept fill level
      do_reset();
      s1 = '{1, 2, 3, 5, 4};
`ifdef MEDIAN_EDGE_REPLICATE_EN
      lv = '{3, 3, 3, 3, 3};
`else
      lv = '{1, 2, 3, 3, 3};
`endif
      for (int i = 0; i < 5; i++) begin
         send(s1[i]);
         chk("t1_fill", int'(fill_level), lv[i]);
      end
      drain();
`ifdef MEDIAN_EDGE_REPLICATE_EN
      want = '{1, 1, 2, 3, 4};
`else
      want = '{2, 3, 4};
`endif
      check_got("t1");

      // Ties
      do_reset();
      foreach (s1[i]) s1[i] = 0;
      send(7); send(7); send(7); send(4); send(4); send(2);
      drain();
`ifdef MEDIAN_EDGE_REPLICATE_EN
      want = '{7, 7, 7, 7, 4, 4};
`else
      want = '{7, 7, 4, 4};
`endif
      check_got("ties");

      // Full-range extremes
      do_reset();
      send(255); send(128); send(0);
      drain();
`ifdef MEDIAN_EDGE_REPLICATE_EN
      want = '{255, 255, 128};
`else
      want = '{128};
`endif
      check_got("extremes");

      do_reset();
      send(0); send(0); send(0);
      drain();
`ifdef MEDIAN_EDGE_REPLICATE_EN
      want = '{0, 0, 0};
`else
      want = '{0};
`endif
      check_got("zeros");

      // Backpressure: hold 42, block 200, then release
      do_reset();
      send(42); send(100); send(17);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 8'd200;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_data", int'(out_data), 42);
      out_ready = 1'b1;
      send(200);
      drain();
`ifdef MEDIAN_EDGE_REPLICATE_EN
      want = '{42, 42, 42, 100};
`else
      want = '{42, 100};
`endif
      check_got("bp");

      // Pending output survives a flush
      do_reset();
      send(10); send(20); send(30);
      out_ready = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("fl_pend_valid", int'(out_valid), 1);
      chk("fl_pend_data", int'(out_data), 20);
      chk("fl_pend_fill", int'(fill_level), 0);
      drain();
`ifdef MEDIAN_EDGE_REPLICATE_EN
      want = '{10, 10, 20};
`else
      want = '{20};
`endif
      check_got("fl_pend");

      // Flush drops the partial window
      do_reset();
      send(5); send(1);
      flush = 1'b1;
      in_valid = 1'b1;
      in_data = 8'd99;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      send(3); send(9); send(6);
      drain();
`ifdef MEDIAN_EDGE_REPLICATE_EN
      want = '{5, 5, 3, 3, 6};
`else
      want = '{6};
`endif
      check_got("flush");

      // Reset mid-stream discards the held output
      do_reset();
      send(1); send(2); send(3); send(8);
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("rm_held", int'(out_valid), 1);
      rst = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      flush = 1'b0;
      chk("rm_out_valid", int'(out_valid), 0);
      chk("rm_out_data", int'(out_data), 0);
      chk("rm_fill", int'(fill_level), 0);
      got.delete();
      out_ready = 1'b1;
      send(1); send(2); send(3);
      drain();
`ifdef MEDIAN_EDGE_REPLICATE_EN
      want = '{1, 1, 2};
`else
      want = '{2};
`endif
      check_got("refill");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/median3_stream_filter.md
# median3_stream_filter

Streaming 3-tap sliding-window median filter built around the existing combinational 3-input median function. Consumes one sample per accepted input beat on a valid/ready stream, keeps the last three samples in a shift window, and emits the window median on a registered valid/ready output stream. It sits between a sample source (ADC/pixel front end) and downstream processing as an impulse-noise rejector.

## Interface
- DATA_W, 8: sample width, unsigned.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  filter can accept a sample this cycle.
- in_data  in  DATA_W  unsigned input sample.
- flush  in  1  drop the partial window and restart fill; single-cycle pulse or level.
- out_valid  out  1  out_data holds a median.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_W  registered median of the current window.
- fill_level  out  2  samples currently held in the window, 0..3.

## Operation
- Window registers w0 (newest), w1, w2 (oldest); fill state FILL0 -> FILL1 -> FILL2 -> RUN, encoded on fill_level as 0/1/2/3.
- Accept = in_valid && in_ready. in_ready = !flush && (!out_valid || out_ready).
- On accept: w2<=w1, w1<=w0, w0<=in_data; fill advances one state, saturating in RUN.
- Output produced on an accept that leaves the window full (FILL2->RUN or RUN->RUN): out_data <= median(in_data, w0, w1), out_valid <= 1.
- Accept in FILL0/FILL1 updates the window only; out_valid unchanged except by the output handshake.
- Output handshake: out_valid && out_ready clears out_valid unless a new median loads the same cycle (then out_valid stays 1, out_data updates).
- Median: unsigned compare, full DATA_W, no arithmetic widening; ties return the tied value (median(4,4,2)=4, median(7,7,7)=7).
- flush: fill -> FILL0 next cycle; window contents don't-care; no sample accepted that cycle; a pending out_valid/out_data is kept and delivered normally.
- flush and rst in the same cycle: rst wins.

## Timing
- Reset values: out_valid=0, out_data=0, fill_level=0, window registers=0; in_ready=1 the cycle after rst deasserts (absent flush).
- Latency: median visible on out_data/out_valid the cycle after the accepting edge (1 cycle).
- Throughput: one sample per cycle with out_ready held high.
- Backpressure: while out_valid=1 and out_ready=0, out_data is stable, in_ready=0, window and fill frozen.
- Without edge mode, N accepted samples after reset/flush yield N-2 outputs (none for N<3).
- rst asserted mid-stream: next cycle all state at reset values; any undelivered output discarded.

## Configuration
- MEDIAN_EDGE_REPLICATE_EN defined: accept in FILL0 loads w0=w1=w2=in_data, goes directly to RUN, and emits median = in_data; every accepted sample thereafter yields one output (N inputs -> N outputs). fill_level reads 3 after the first accept.
- Not defined: fill behaviour as in Operation; outputs start at the third sample.

## Test plan
- Macro off, stream 1,2,3,5,4 with out_ready=1 -> outputs 2,3,4 exactly, each 1 cycle after its third-or-later accept; fill_level 1,2,3,3,3.
- Macro on, same stream -> outputs 1,1,2,3,4; out_valid asserted after the first accept.
- Ties and edges: stream 7,7,7,4,4,2 -> 7,7,4,4; stream 255,128,0 -> 128; 0,0,0 -> 0.
- Backpressure: stream 42,100,17,200 with out_ready=0 after first output -> out_data holds 42, in_ready=0, 200 not accepted; release out_ready -> 42 then 100 (median of 100,17,200).
- Flush: 5,1,flush,3,9,6 (macro off) -> no output until 3,9,6 -> 6; pending output present at flush is still delivered.
- Reset mid-stream: rst during RUN with out_valid=1 -> next cycle out_valid=0, out_data=0, fill_level=0; refill 1,2,3 -> 2.
